// File: rtl/led_pkg.sv
// Shared definitions for the LED PWM array: channel modes, write-data field
// positions, the per-channel configuration record and the per-channel decode.
package led_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_PWM   = 2'd2,
        LED_BLINK = 2'd3
    } led_mode_t;

    localparam int DUTY_LSB     = 0;
    localparam int MODE_LSB     = 8;
    localparam int MAX_PWM_BITS = 8;

    // Duty is stored at the widest supported size; unused upper bits stay 0.
    typedef struct packed {
        led_mode_t                 mode;
        logic [MAX_PWM_BITS-1:0]   duty;
    } led_cfg_t;

    // Decide whether one channel is lit for the given counter and blink phase.
    function automatic logic led_decode(input led_cfg_t cfg,
                                        input logic [MAX_PWM_BITS-1:0] cnt,
                                        input logic blink_phase);
        logic lit;
        lit = 1'b0;
        case (cfg.mode)
            LED_OFF:   lit = 1'b0;
            LED_ON:    lit = 1'b1;
            LED_PWM:   lit = (cnt < cfg.duty);
            LED_BLINK: lit = (cnt < cfg.duty) && !blink_phase;
            default:   lit = 1'b0;
        endcase
        return lit;
    endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// Shared time base for all LED channels: prescaler, PWM count within a frame
// and a frame counter whose MSB is the blink phase.
// The reset port is active low (reset==0 clears everything).
module led_pwm_timebase #(
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned PRESCALE   = 256,
    parameter int unsigned BLINK_BITS = 6
) (
    input  logic                clk,
    input  logic                reset,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                frame_wrap,
    output logic                blink_phase
);

    // A prescale of 1 still needs a one-bit register that simply stays at 0.
    localparam int unsigned      PS_BITS = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_BITS-1:0] PS_LAST = PS_BITS'(PRESCALE - 1);

    logic [PS_BITS-1:0]    prescale;
    logic                  tick;
    logic [BLINK_BITS-1:0] frame_cnt;

    assign tick        = (prescale == PS_LAST);
    assign frame_wrap  = tick && (pwm_cnt == '1);
    assign blink_phase = frame_cnt[BLINK_BITS-1];

    // Prescaler: free-running 0..PRESCALE-1, one PWM tick per wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale <= '0;
        end else if (tick) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + 1'b1;
        end
    end

    // PWM counter: advances on each tick and wraps naturally at full scale.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Frame counter: one step per PWM frame, drives the blink phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
        end else if (frame_wrap) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_pwm_array.sv
// Multi-channel LED driver with off/on/PWM/blink modes. Writes land in a
// shadow register per channel and are copied to the active set only at a
// frame wrap, so a channel never changes duty mid-frame.
// The reset port is active low (reset==0 clears everything).
module led_pwm_array
    import led_pkg::*;
#(
    parameter int unsigned CHANNELS   = 16,
    parameter int unsigned ADDR_BITS  = 4,
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned PRESCALE   = 256,
    parameter int unsigned BLINK_BITS = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [15:0]          data,
    output logic [CHANNELS-1:0]  ext_red_led,
    output logic                 frame_start
);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic                frame_wrap;
    logic                blink_phase;
    logic                wrap_q;
    led_cfg_t            wr_cfg;
    logic [CHANNELS-1:0] lit;
    logic                unused_data_bits;

    led_pwm_timebase #(
        .PWM_BITS   (PWM_BITS),
        .PRESCALE   (PRESCALE),
        .BLINK_BITS (BLINK_BITS)
    ) u_timebase (
        .clk         (clk),
        .reset       (reset),
        .pwm_cnt     (pwm_cnt),
        .frame_wrap  (frame_wrap),
        .blink_phase (blink_phase)
    );

    // Only the duty and mode fields of the write data carry meaning.
    assign unused_data_bits = ^data;

    // Unpack the write data into a channel configuration record.
    always_comb begin
        wr_cfg                      = '0;
        wr_cfg.mode                 = led_mode_t'(data[MODE_LSB +: 2]);
        wr_cfg.duty[PWM_BITS-1:0]   = data[DUTY_LSB +: PWM_BITS];
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        led_cfg_t shadow;
        led_cfg_t active;
        logic     hit;

        // Addresses at or above CHANNELS match no channel and are dropped.
        assign hit = we && (addr == ADDR_BITS'(i));

        // Shadow register: the last write before a frame wrap wins.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                shadow <= '0;
            end else if (hit) begin
                shadow <= wr_cfg;
            end
        end

        // Active register: reloads at frame wrap; a write in that very cycle bypasses the shadow.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                active <= '0;
            end else if (frame_wrap) begin
                active <= hit ? wr_cfg : shadow;
            end
        end

        assign lit[i] = led_decode(active, MAX_PWM_BITS'(pwm_cnt), blink_phase);
    end

    // Output registers; frame_start is the wrap delayed twice so it lines up
    // with the first registered LED value of the new frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_red_led <= '0;
            wrap_q      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            ext_red_led <= lit;
            wrap_q      <= frame_wrap;
            frame_start <= wrap_q;
        end
    end

endmodule

// File: tb/tb_led_pwm_array.sv
// Self-checking bench for led_pwm_array. Two instances share clock, reset and
// write port: dut_a (4 channels, prescale 1) and dut_b (3 channels, prescale 4).
// A cycle-indexed reference model predicts both instances' outputs.
module tb_led_pwm_array;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       we    = 1'b0;
    logic [1:0] addr  = 2'd0;
    logic [15:0] data = 16'd0;

    logic [3:0] led_a;
    logic       fs_a;
    logic [2:0] led_b;
    logic       fs_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_pwm_array #(
        .CHANNELS(4), .ADDR_BITS(2), .PWM_BITS(3), .PRESCALE(1), .BLINK_BITS(2)
    ) dut_a (
        .clk(clk), .reset(reset), .we(we), .addr(addr), .data(data),
        .ext_red_led(led_a), .frame_start(fs_a)
    );

    led_pwm_array #(
        .CHANNELS(3), .ADDR_BITS(2), .PWM_BITS(3), .PRESCALE(4), .BLINK_BITS(2)
    ) dut_b (
        .clk(clk), .reset(reset), .we(we), .addr(addr), .data(data),
        .ext_red_led(led_b), .frame_start(fs_b)
    );

    // ---------------- reference model ----------------
    // Index 0 models dut_a, index 1 models dut_b. m_t counts clock edges since
    // reset release; counter values are derived from it arithmetically.
    int     m_t[2];
    int     sh_mode[2][4];
    int     sh_duty[2][4];
    int     ac_mode[2][4];
    int     ac_duty[2][4];
    bit [3:0] exp_led[2];
    bit       exp_fs[2];

    function automatic int n_ch(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic int n_ps(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_t[d]     = 0;
            exp_led[d] = '0;
            exp_fs[d]  = 1'b0;
            for (int c = 0; c < 4; c++) begin
                sh_mode[d][c] = 0;
                sh_duty[d][c] = 0;
                ac_mode[d][c] = 0;
                ac_duty[d][c] = 0;
            end
        end
    endtask

    task automatic model_step(input int d);
        int k, p, frame_len, cnt;
        bit dark;
        bit [3:0] nxt;
        k         = m_t[d];
        p         = n_ps(d);
        frame_len = 8 * p;
        cnt       = (k / p) % 8;
        dark      = ((k / frame_len) % 4) >= 2;
        nxt       = '0;
        for (int c = 0; c < n_ch(d); c++) begin
            case (ac_mode[d][c])
                1:       nxt[c] = 1'b1;
                2:       nxt[c] = (cnt < ac_duty[d][c]);
                3:       nxt[c] = (cnt < ac_duty[d][c]) && !dark;
                default: nxt[c] = 1'b0;
            endcase
        end
        exp_led[d] = nxt;
        exp_fs[d]  = (k > 0) && (k % frame_len == 0);
        if (we && int'(addr) < n_ch(d)) begin
            sh_mode[d][addr] = int'(data[9:8]);
            sh_duty[d][addr] = int'(data[2:0]);
        end
        if ((k + 1) % frame_len == 0) begin
            for (int c = 0; c < 4; c++) begin
                ac_mode[d][c] = sh_mode[d][c];
                ac_duty[d][c] = sh_duty[d][c];
            end
        end
        m_t[d] = k + 1;
    endtask

    // Advance the model on every clock edge; clear it on reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_clear();
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at a negedge; drives a single-cycle write, then leaves junk on the bus.
    task automatic write_reg(input logic [1:0] a, input logic [15:0] d);
        we   = 1'b1;
        addr = a;
        data = d;
        @(negedge clk);
        we   = 1'b0;
        addr = 2'($urandom);
        data = 16'($urandom);
    endtask

    task automatic wait_fs_a(input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while (fs_a !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (fs_a !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_fs_a: got no frame_start within %0d cycles, required a pulse", limit);
        end
    endtask

    task automatic wait_fs_b(input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while (fs_b !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (fs_b !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_fs_b: got no frame_start within %0d cycles, required a pulse", limit);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int first_a, second_a, first_b;
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checks += 4;
            if (led_a !== 4'b0000) begin errors++; $display("[TB] FAIL reset_led_a: got %b expected 0000", led_a); end
            if (led_b !== 3'b000)  begin errors++; $display("[TB] FAIL reset_led_b: got %b expected 000", led_b); end
            if (fs_a !== 1'b0)     begin errors++; $display("[TB] FAIL reset_fs_a: got %b expected 0", fs_a); end
            if (fs_b !== 1'b0)     begin errors++; $display("[TB] FAIL reset_fs_b: got %b expected 0", fs_b); end
        end
        reset    = 1'b1;
        first_a  = -1;
        second_a = -1;
        first_b  = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (fs_a === 1'b1) begin
                if (first_a < 0) first_a = cyc;
                else if (second_a < 0) second_a = cyc;
            end
            if (fs_b === 1'b1 && first_b < 0) first_b = cyc;
            checks += 2;
            if (fs_a !== exp_fs[0]) begin errors++; $display("[TB] FAIL release_fs_a: got %b expected %b at cycle %0d", fs_a, exp_fs[0], cyc); end
            if (fs_b !== exp_fs[1]) begin errors++; $display("[TB] FAIL release_fs_b: got %b expected %b at cycle %0d", fs_b, exp_fs[1], cyc); end
        end
        checks += 3;
        if (first_a != 9)   begin errors++; $display("[TB] FAIL first_fs_a: got cycle %0d expected 9", first_a); end
        if (second_a != 17) begin errors++; $display("[TB] FAIL second_fs_a: got cycle %0d expected 17", second_a); end
        if (first_b != 33)  begin errors++; $display("[TB] FAIL first_fs_b: got cycle %0d expected 33", first_b); end
    endtask

    task automatic test_pwm_duty();
        int duties[4];
        int lit_cnt;
        duties = '{3, 0, 7, 0};
        duties[3] = int'($urandom_range(1, 6));
        for (int t = 0; t < 4; t++) begin
            wait_fs_a(20);
            write_reg(2'd0, 16'h0200 | 16'(duties[t]));
            wait_fs_a(20);
            lit_cnt = 0;
            for (int i = 0; i < 8; i++) begin
                if (i > 0) @(negedge clk);
                if (led_a[0] === 1'b1) lit_cnt++;
                checks += 2;
                if (led_a !== exp_led[0])      begin errors++; $display("[TB] FAIL pwm_led_a: got %b expected %b", led_a, exp_led[0]); end
                if (led_b !== exp_led[1][2:0]) begin errors++; $display("[TB] FAIL pwm_led_b: got %b expected %b", led_b, exp_led[1][2:0]); end
            end
            checks++;
            if (lit_cnt != duties[t]) begin errors++; $display("[TB] FAIL pwm_lit_count: got %0d of 8 expected %0d", lit_cnt, duties[t]); end
        end
    endtask

    task automatic test_last_write_wins();
        wait_fs_a(20);
        write_reg(2'd1, 16'h0100);
        write_reg(2'd1, 16'h0000);
        write_reg(2'd2, 16'h0100);
        wait_fs_a(20);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            checks += 3;
            if (led_a[1] !== 1'b0)     begin errors++; $display("[TB] FAIL last_write_ch1: got %b expected 0", led_a[1]); end
            if (led_a[2] !== 1'b1)     begin errors++; $display("[TB] FAIL on_ch2: got %b expected 1", led_a[2]); end
            if (led_a !== exp_led[0])  begin errors++; $display("[TB] FAIL lww_led_a: got %b expected %b", led_a, exp_led[0]); end
        end
    endtask

    task automatic test_blink();
        int lit_cnt;
        wait_fs_a(20);
        write_reg(2'd3, 16'h0307);
        wait_fs_a(20);
        lit_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (i > 0) @(negedge clk);
            if (led_a[3] === 1'b1) lit_cnt++;
            checks += 2;
            if (led_a !== exp_led[0]) begin errors++; $display("[TB] FAIL blink_led_a: got %b expected %b", led_a, exp_led[0]); end
            if (fs_a !== exp_fs[0])   begin errors++; $display("[TB] FAIL blink_fs_a: got %b expected %b", fs_a, exp_fs[0]); end
        end
        checks++;
        if (lit_cnt != 14) begin errors++; $display("[TB] FAIL blink_lit_count: got %0d of 32 expected 14", lit_cnt); end
    endtask

    task automatic test_bypass();
        wait_fs_a(20);
        write_reg(2'd0, 16'h0000);
        wait_fs_a(20);
        repeat (6) @(negedge clk);
        write_reg(2'd0, 16'h0100);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks += 2;
            if (i == 0 && fs_a !== 1'b1) begin errors++; $display("[TB] FAIL bypass_fs_a: got %b expected 1", fs_a); end
            if (led_a[0] !== 1'b1)       begin errors++; $display("[TB] FAIL bypass_ch0: got %b expected 1 at cycle %0d", led_a[0], i); end
        end
        write_reg(2'd3, 16'h0100);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            checks += 2;
            if (led_b !== exp_led[1][2:0]) begin errors++; $display("[TB] FAIL oob_led_b: got %b expected %b", led_b, exp_led[1][2:0]); end
            if (led_a !== exp_led[0])      begin errors++; $display("[TB] FAIL oob_led_a: got %b expected %b", led_a, exp_led[0]); end
        end
    endtask

    task automatic test_prescale_and_reset();
        int lit_cnt;
        wait_fs_b(40);
        write_reg(2'd0, 16'h0202);
        wait_fs_b(40);
        lit_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (i > 0) @(negedge clk);
            if (led_b[0] === 1'b1) lit_cnt++;
            checks += 2;
            if (led_b !== exp_led[1][2:0]) begin errors++; $display("[TB] FAIL ps_led_b: got %b expected %b", led_b, exp_led[1][2:0]); end
            if (fs_b !== exp_fs[1])        begin errors++; $display("[TB] FAIL ps_fs_b: got %b expected %b", fs_b, exp_fs[1]); end
        end
        checks++;
        if (lit_cnt != 8) begin errors++; $display("[TB] FAIL ps_lit_count: got %0d of 32 expected 8", lit_cnt); end
        @(posedge clk);
        #1;
        checks++;
        if (led_b[0] !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_ch0: got %b expected 1", led_b[0]); end
        reset = 1'b0;
        #1;
        checks += 4;
        if (led_a !== 4'b0000) begin errors++; $display("[TB] FAIL async_led_a: got %b expected 0000", led_a); end
        if (led_b !== 3'b000)  begin errors++; $display("[TB] FAIL async_led_b: got %b expected 000", led_b); end
        if (fs_a !== 1'b0)     begin errors++; $display("[TB] FAIL async_fs_a: got %b expected 0", fs_a); end
        if (fs_b !== 1'b0)     begin errors++; $display("[TB] FAIL async_fs_b: got %b expected 0", fs_b); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks += 2;
            if (led_b[0] !== 1'b0)    begin errors++; $display("[TB] FAIL post_reset_ch0: got %b expected 0", led_b[0]); end
            if (led_a !== exp_led[0]) begin errors++; $display("[TB] FAIL post_reset_led_a: got %b expected %b", led_a, exp_led[0]); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            we   = ($urandom_range(0, 3) == 0);
            addr = 2'($urandom);
            data = 16'($urandom);
            @(negedge clk);
            checks += 4;
            if (led_a !== exp_led[0])      begin errors++; $display("[TB] FAIL rand_led_a: got %b expected %b at step %0d", led_a, exp_led[0], i); end
            if (led_b !== exp_led[1][2:0]) begin errors++; $display("[TB] FAIL rand_led_b: got %b expected %b at step %0d", led_b, exp_led[1][2:0], i); end
            if (fs_a !== exp_fs[0])        begin errors++; $display("[TB] FAIL rand_fs_a: got %b expected %b at step %0d", fs_a, exp_fs[0], i); end
            if (fs_b !== exp_fs[1])        begin errors++; $display("[TB] FAIL rand_fs_b: got %b expected %b at step %0d", fs_b, exp_fs[1], i); end
        end
        we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pwm_duty();
        test_last_write_wins();
        test_blink();
        test_bypass();
        test_prescale_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
